heart_rate_meter: RTL and testbench

- Consumes the one-bit peak indicator from the peak-finder stage and measures the inter-beat interval in clk cycles.
- Averages the last 2^AVG_LOG2 intervals and converts the average to beats per minute with a sequential restoring divider.
- Drives the display path (digit extraction / seven-segment mux) with an 8-bit BPM value and a one-cycle update strobe.
- Replaces the fixed 10 s window peak count with an interval-based rate, giving faster updates and finer resolution.

---
 rtl/heart_rate_meter_if.sv | 25 ++
 rtl/heart_rate_meter.sv | 206 ++++++++++++++++++++
 tb/tb_heart_rate_meter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/heart_rate_meter_if.sv
// Peak-in / rate-out signal bundle between the peak finder and the heart rate meter.
// The master side (the peak finder) drives peak_in; the slave side (the meter) drives the rest.
interface heart_rate_meter_if;
   logic       peak_in;
   logic [7:0] bpm;
   logic       bpm_valid;
   logic       beat_lost;
   logic       busy;

   modport master (
      output peak_in,
      input  bpm,
      input  bpm_valid,
      input  beat_lost,
      input  busy
   );

   modport slave (
      input  peak_in,
      output bpm,
      output bpm_valid,
      output beat_lost,
      output busy
   );
endinterface

// File: rtl/heart_rate_meter.sv
// Interval-based heart rate meter: measures the cycle distance between qualifying peak edges,
// averages the last 2^AVG_LOG2 intervals and converts the average to BPM with a restoring
// divider (one quotient bit per cycle).
// Optional macro HR_BPM_ROUND_EN: rounds to nearest by adding avg/2 to the dividend
// (33-bit dividend, 33 divider iterations).
module heart_rate_meter #(
   parameter int unsigned CLK_HZ       = 40000000,
   parameter int unsigned MIN_INTERVAL = 10000000,
   parameter int unsigned MAX_INTERVAL = 80000000,
   parameter int unsigned AVG_LOG2     = 2
) (
   input logic              clk,
   input logic              reset,
   heart_rate_meter_if.slave hr
);

   localparam int unsigned DEPTH   = 1 << AVG_LOG2;
   localparam logic [3:0]  DEPTH_W = 4'(DEPTH);
   localparam logic [31:0] NUMER   = 32'(60 * CLK_HZ);
   localparam logic [31:0] MIN_W   = 32'(MIN_INTERVAL);
   localparam logic [31:0] MAX_W   = 32'(MAX_INTERVAL);
`ifdef HR_BPM_ROUND_EN
   localparam int unsigned DW = 33;
`else
   localparam int unsigned DW = 32;
`endif
   localparam logic [5:0]  LAST_IT = 6'(DW - 1);

   typedef enum logic [1:0] {StWaitFirst, StTrack, StDivide} state_t;

   state_t         state_q, state_d;
   logic           peak_q, peak_qq;
   logic [31:0]    cnt_q, cnt_d;
   logic [31:0]    hist_q [DEPTH];
   logic [31:0]    hist_d [DEPTH];
   logic [34:0]    sum_q, sum_d;
   logic [3:0]     fill_q, fill_d;
   logic           push_q, push_d;
   logic           pending_q, pending_d;
   logic           lost_q, lost_d;
   logic [7:0]     bpm_q, bpm_d;
   logic           valid_q, valid_d;
   logic [31:0]    dv_q, dv_d;
   logic [DW-1:0]  dq_q, dq_d;
   logic [31:0]    rem_q, rem_d;
   logic [5:0]     it_q, it_d;

   logic           rise, timeout, accept;
   logic [32:0]    rem_sh;
   logic           fits;
   logic [31:0]    rem_sub;
   logic [DW-1:0]  dq_nx;
   logic [31:0]    avg;
   logic [DW-1:0]  div_init;

   assign rise    = peak_q & ~peak_qq;
   assign timeout = (state_q != StWaitFirst) && (cnt_q > MAX_W);
   assign accept  = rise && !timeout && ((state_q == StWaitFirst) || (cnt_q >= MIN_W));
   assign avg     = sum_q[AVG_LOG2 +: 32];

   // One restoring-division step plus the dividend to load when a division starts
   always_comb begin
      rem_sh  = {rem_q, dq_q[DW-1]};
      fits    = rem_sh >= {1'b0, dv_q};
      // Only used when fits, so the true difference is below 2^32
      rem_sub = rem_sh[31:0] - dv_q;
      dq_nx   = {dq_q[DW-2:0], fits};
`ifdef HR_BPM_ROUND_EN
      div_init = {1'b0, NUMER} + {2'b0, sum_q[AVG_LOG2+1 +: 31]};
`else
      div_init = NUMER;
`endif
   end

   // Next-state logic: interval counter, history, FSM and divider
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hist_d    = hist_q;
      sum_d     = sum_q;
      fill_d    = fill_q;
      push_d    = 1'b0;
      pending_d = pending_q;
      lost_d    = lost_q;
      bpm_d     = bpm_q;
      valid_d   = 1'b0;
      dv_d      = dv_q;
      dq_d      = dq_q;
      rem_d     = rem_q;
      it_d      = it_q;

      // Counter restarts at 1 so that its value at the next edge equals the interval
      if (accept) begin
         cnt_d  = 32'd1;
         lost_d = 1'b0;
      end else if (cnt_q <= MAX_W) begin
         cnt_d = cnt_q + 32'd1;
      end

      if (accept && (state_q != StWaitFirst)) begin
         for (int i = DEPTH - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
         hist_d[0] = cnt_q;
         sum_d     = sum_q + {3'b0, cnt_q} - {3'b0, hist_q[DEPTH-1]};
         fill_d    = (fill_q == DEPTH_W) ? fill_q : fill_q + 4'd1;
         push_d    = 1'b1;
      end

      unique case (state_q)
         StWaitFirst: begin
            if (accept) state_d = StTrack;
         end
         StTrack: begin
            if (timeout) begin
               state_d = StWaitFirst;
            end else if (push_q && (fill_q == DEPTH_W)) begin
               state_d = StDivide;
               dv_d    = avg;
               dq_d    = div_init;
               rem_d   = '0;
               it_d    = '0;
            end
         end
         StDivide: begin
            if (!timeout) begin
               if (push_q) pending_d = 1'b1;
               rem_d = fits ? rem_sub : rem_sh[31:0];
               dq_d  = dq_nx;
               it_d  = it_q + 6'd1;
               if (it_q == LAST_IT) begin
                  valid_d = 1'b1;
                  bpm_d   = (|dq_nx[DW-1:8]) ? 8'hff : dq_nx[7:0];
                  if (pending_q || push_q) begin
                     // History moved on while dividing: restart with the fresh average
                     pending_d = 1'b0;
                     dv_d      = avg;
                     dq_d      = div_init;
                     rem_d     = '0;
                     it_d      = '0;
                  end else begin
                     state_d = StTrack;
                  end
               end
            end else begin
               state_d = StWaitFirst;
            end
         end
         default: state_d = StWaitFirst;
      endcase

      // Beat lost: drop the history and start over from the first edge
      if (timeout) begin
         lost_d    = 1'b1;
         bpm_d     = 8'd0;
         valid_d   = 1'b0;
         pending_d = 1'b0;
         sum_d     = '0;
         fill_d    = '0;
         for (int i = 0; i < DEPTH; i++) hist_d[i] = '0;
      end
   end

   // State register with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StWaitFirst;
         peak_q    <= 1'b0;
         peak_qq   <= 1'b0;
         cnt_q     <= '0;
         for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
         sum_q     <= '0;
         fill_q    <= '0;
         push_q    <= 1'b0;
         pending_q <= 1'b0;
         lost_q    <= 1'b0;
         bpm_q     <= '0;
         valid_q   <= 1'b0;
         dv_q      <= '0;
         dq_q      <= '0;
         rem_q     <= '0;
         it_q      <= '0;
      end else begin
         state_q   <= state_d;
         peak_q    <= hr.peak_in;
         peak_qq   <= peak_q;
         cnt_q     <= cnt_d;
         hist_q    <= hist_d;
         sum_q     <= sum_d;
         fill_q    <= fill_d;
         push_q    <= push_d;
         pending_q <= pending_d;
         lost_q    <= lost_d;
         bpm_q     <= bpm_d;
         valid_q   <= valid_d;
         dv_q      <= dv_d;
         dq_q      <= dq_d;
         rem_q     <= rem_d;
         it_q      <= it_d;
      end
   end

   assign hr.bpm       = bpm_q;
   assign hr.bpm_valid = valid_q;
   assign hr.beat_lost = lost_q;
   assign hr.busy      = (state_q == StDivide);

endmodule

// File: tb/tb_heart_rate_meter.sv
// Directed bench for heart_rate_meter with a scoreboard of expected BPM updates.
module tb_heart_rate_meter;

   localparam int unsigned CLK_HZ   = 1000;
   localparam int unsigned MIN_INT  = 200;
   localparam int unsigned MAX_INT  = 2000;
   localparam int unsigned AVG_LOG2 = 2;
`ifdef HR_BPM_ROUND_EN
   localparam int LAT   = 36;
   localparam bit ROUND = 1'b1;
`else
   localparam int LAT   = 35;
   localparam bit ROUND = 1'b0;
`endif

   typedef struct {
      int val;
      int at;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   nchk = 0;
   int   nerr = 0;
   int   npulse = 0;
   int   nexp = 0;
   exp_t sb[$];
   int   hist[$];
   int   last_e = -1;

   heart_rate_meter_if hr ();

   heart_rate_meter #(
      .CLK_HZ      (CLK_HZ),
      .MIN_INTERVAL(MIN_INT),
      .MAX_INTERVAL(MAX_INT),
      .AVG_LOG2    (AVG_LOG2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .hr   (hr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int expv);
      nchk++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // Scoreboard consumer: every bpm_valid must match the oldest expected update
   always @(negedge clk) begin : mon
      exp_t e;
      if (hr.bpm_valid === 1'b1) begin
         npulse++;
         if (sb.size() == 0) begin
            chk("spurious_bpm_valid", int'(hr.bpm_valid), 0);
         end else begin
            e = sb.pop_front();
            chk("bpm_value", int'(hr.bpm), e.val);
            chk("bpm_time", cyc, e.at);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic pulse(input int t, input int w);
      wait_cyc(t);
      hr.peak_in = 1'b1;
      wait_cyc(t + w);
      hr.peak_in = 1'b0;
   endtask

   // Qualifying beat driven at cycle t; the model records the interval and predicts any update
   task automatic beat(input int t, input int w);
      exp_t        e;
      int unsigned s, avg, dvd, q;
      if (last_e >= 0) begin
         hist.push_back(t - last_e);
         if (hist.size() > 4) void'(hist.pop_front());
         if (hist.size() == 4) begin
            s = 0;
            foreach (hist[i]) s += hist[i];
            avg = s >> AVG_LOG2;
            dvd = 60 * CLK_HZ + (ROUND ? (avg >> 1) : 0);
            q   = dvd / avg;
            e.val = (q > 255) ? 255 : int'(q);
            e.at  = t + LAT;
            sb.push_back(e);
            nexp++;
         end
      end
      last_e = t;
      pulse(t, w);
   endtask

   initial begin
      hr.peak_in = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_bpm", int'(hr.bpm), 0);
      chk("reset_valid", int'(hr.bpm_valid), 0);
      chk("reset_lost", int'(hr.beat_lost), 0);
      chk("reset_busy", int'(hr.busy), 0);
      @(negedge clk);
      reset = 1'b0;

      // Five 1000-cycle beats: one update only after the fifth edge
      beat(20, 5);
      beat(1020, 5);
      beat(2020, 5);
      beat(3020, 5);
      wait_cyc(4000);
      chk("no_update_yet_bpm", int'(hr.bpm), 0);
      beat(4020, 2);
      chk("busy_e1", int'(hr.busy), 0);
      wait_cyc(4023);
      chk("busy_e2", int'(hr.busy), 1);
      wait_cyc(4055);
      chk("busy_done", int'(hr.busy), 0);

      // Steady then faster rhythm
      beat(5020, 5);
      beat(5820, 5);
      beat(6620, 5);
      beat(7420, 5);
      beat(8220, 5);

      // Back to 1000, then a long-held peak and an early spurious edge
      beat(9220, 5);
      beat(10220, 5);
      beat(11220, 5);
      beat(12220, 5);
      beat(13220, 50);
      pulse(13320, 5);
      beat(14220, 5);

      // Timeout: beat_lost just before and after the limit
      wait_cyc(14221 + 1990);
      chk("lost_before_limit", int'(hr.beat_lost), 0);
      wait_cyc(14221 + 2005);
      chk("lost_after_limit", int'(hr.beat_lost), 1);
      chk("lost_bpm_zero", int'(hr.bpm), 0);
      hist.delete();
      last_e = -1;
      beat(16500, 5);
      wait_cyc(16510);
      chk("lost_cleared", int'(hr.beat_lost), 0);
      beat(17250, 5);
      beat(18000, 5);
      beat(18750, 5);
      beat(19500, 5);

      // 700-cycle and 210-cycle (saturating) rhythms
      beat(20200, 5);
      beat(20900, 5);
      beat(21600, 5);
      beat(22300, 5);
      beat(22510, 5);
      beat(22720, 5);
      beat(22930, 5);
      beat(23140, 5);

      // Reset in the middle of a division
      beat(24140, 5);
      wait_cyc(24151);
      chk("busy_before_reset", int'(hr.busy), 1);
      reset = 1'b1;
      #1;
      chk("midreset_bpm", int'(hr.bpm), 0);
      chk("midreset_valid", int'(hr.bpm_valid), 0);
      chk("midreset_lost", int'(hr.beat_lost), 0);
      chk("midreset_busy", int'(hr.busy), 0);
      nexp -= sb.size();
      sb.delete();
      hist.delete();
      last_e = -1;
      @(negedge clk);
      reset = 1'b0;
      beat(24300, 5);
      beat(25300, 5);
      beat(26300, 5);
      beat(27300, 5);
      beat(28300, 5);
      wait_cyc(28320);
      chk("post_reset_bpm_held", int'(hr.bpm), 0);
      chk("post_reset_busy", int'(hr.busy), 1);

      wait_cyc(28400);
      chk("scoreboard_drained", sb.size(), 0);
      chk("update_count", npulse, nexp);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
